// File: rtl/alu_result_display_if.sv
// Purpose : bundles the ALU-result inputs (F, flags, capture button, live
//           select) and the display outputs (seg, an, led) of the display block.
// Latency : none, wires only.
// Backpressure : none; the display is a free-running sink with no stall path.
// Ports (slave = display block side):
//   F[31:0], ZF, CF, OF, SF  ALU result and flags into the display
//   btn                      raw capture push-button, asynchronous, active-high
//   live                     1 = show live inputs, 0 = show held snapshot
//   seg[7:0]                 {dp,g,f,e,d,c,b,a}, active-low
//   an[7:0]                  digit enables, active-low, bit 0 = rightmost digit
//   led[7:0]                 {cap_cnt[3:0], SF, OF, CF, ZF}, active-high
interface alu_result_display_if;
  logic [31:0] F;
  logic        ZF;
  logic        CF;
  logic        OF;
  logic        SF;
  logic        btn;
  logic        live;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic [7:0]  led;

  // master: whoever produces the ALU result and watches the display
  modport master (
    output F, ZF, CF, OF, SF, btn, live,
    input  seg, an, led
  );

  // slave: the display block itself
  modport slave (
    input  F, ZF, CF, OF, SF, btn, live,
    output seg, an, led
  );
endinterface

// File: rtl/alu_result_display.sv
// Purpose : shows ALU result F in hex on an 8-digit multiplexed 7-segment
//           display and flags plus a capture count on LEDs; live or held view.
// Latency : seg/an/led are registered, one clock after the scan index and
//           source select; a button press captures ~DB_CNT+4 clocks after it
//           settles.
// Backpressure : none; inputs are sampled every clock, the display never stalls.
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   bus   alu_result_display_if.slave (F, flags, btn, live in; seg, an, led out)
module alu_result_display #(
  parameter int SCAN_DIV = 16,     // one digit step every 2^SCAN_DIV clocks
  parameter int DB_CNT   = 500000  // debounce stability window in clocks
) (
  input  logic               clk,
  input  logic               rst,
  alu_result_display_if.slave bus
);

  localparam int DBW = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CNT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                stable_q, stable_d;
  logic                stable_dly_q, stable_dly_d;
  logic [DBW-1:0]      db_cnt_q, db_cnt_d;

  logic [31:0]         held_f_q, held_f_d;
  logic [3:0]          held_flags_q, held_flags_d;  // {SF,OF,CF,ZF}
  logic [3:0]          cap_cnt_q, cap_cnt_d;

  logic [SCAN_DIV-1:0] scan_q, scan_d;
  logic [2:0]          idx_q, idx_d;

  logic [7:0]          seg_q, seg_d;
  logic [7:0]          an_q, an_d;
  logic [7:0]          led_q, led_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                cap;
  logic [3:0]          live_flags;
  logic [31:0]         src_f;
  logic [3:0]          src_flags;
  logic [3:0]          nib;
  logic                stale;

  // Active-low g..a pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Button synchroniser and debouncer
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d      = bus.btn;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    db_cnt_d     = db_cnt_q;
    stable_dly_d = stable_q;
    // Any sample that agrees with the debounced level restarts the window, so
    // only an uninterrupted run of DB_CNT disagreeing samples flips stable.
    if (sync2_q == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      stable_d = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Rising edge of the debounced level: exactly one pulse per press, none on
  // release.
  assign cap = stable_q & ~stable_dly_q;

  // ---------------------------------------------------------------------------
  // Snapshot capture (independent of live)
  // ---------------------------------------------------------------------------
  assign live_flags = {bus.SF, bus.OF, bus.CF, bus.ZF};

  always_comb begin
    held_f_d     = held_f_q;
    held_flags_d = held_flags_q;
    cap_cnt_d    = cap_cnt_q;
    if (cap) begin
      held_f_d     = bus.F;
      held_flags_d = live_flags;
      cap_cnt_d    = cap_cnt_q + 4'd1;  // 4-bit wrap 15 -> 0
    end
  end

  // ---------------------------------------------------------------------------
  // Scan prescaler and digit index
  // ---------------------------------------------------------------------------
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (&scan_q) begin
      idx_d = idx_q + 3'd1;  // 3-bit wrap 7 -> 0
    end
  end

  // ---------------------------------------------------------------------------
  // Source select and output formatting
  // ---------------------------------------------------------------------------
  assign src_f     = bus.live ? bus.F      : held_f_q;
  assign src_flags = bus.live ? live_flags : held_flags_q;
  assign nib       = src_f[{idx_q, 2'b00} +: 4];

  // In hold mode the rightmost decimal point warns that the snapshot no longer
  // matches what the ALU is producing now.
  assign stale = ~bus.live & (held_f_q != bus.F);

  always_comb begin
    seg_d = {~(stale && (idx_q == 3'd0)), hex7(nib)};
    an_d  = ~(8'b1 << idx_q);
    led_d = {cap_cnt_q, src_flags};
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      db_cnt_q     <= '0;
      held_f_q     <= 32'h0;
      held_flags_q <= 4'h0;
      cap_cnt_q    <= 4'h0;
      scan_q       <= '0;
      idx_q        <= 3'd0;
      seg_q        <= 8'hFF;
      an_q         <= 8'hFF;
      led_q        <= 8'h00;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      db_cnt_q     <= db_cnt_d;
      held_f_q     <= held_f_d;
      held_flags_q <= held_flags_d;
      cap_cnt_q    <= cap_cnt_d;
      scan_q       <= scan_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      led_q        <= led_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.led = led_q;

endmodule
